// File: rtl/maze_scene_renderer_if.sv
// Byte-sender link between the maze renderer and a TFT byte transmitter.
// The renderer is the master; the sender answers with tft_busy.
interface maze_scene_renderer_if;
    logic       tft_busy;
    logic       tft_dc;
    logic [7:0] tft_data;
    logic       tft_transmit;

    modport master (
        input  tft_busy,
        output tft_dc,
        output tft_data,
        output tft_transmit
    );

    modport slave (
        output tft_busy,
        input  tft_dc,
        input  tft_data,
        input  tft_transmit
    );
endinterface

// File: rtl/maze_scene_renderer.sv
// Streams a maze frame (walls, food, background) pixel by pixel as colour
// bytes, MSB first, to a TFT byte sender with a strobe/busy handshake.
module maze_scene_renderer #(
    parameter int SCENE_WIDTH     = 320,
    parameter int SCENE_HEIGHT    = 480,
    parameter int CELL_SIZE       = 16,
    parameter int WALL_THICK      = 2,
    parameter int BYTES_PER_PIXEL = 3,
    localparam int COLS = SCENE_WIDTH / CELL_SIZE,
    localparam int ROWS = SCENE_HEIGHT / CELL_SIZE,
    localparam int FXW  = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int FYW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [(ROWS+1)*COLS-1:0]   h_walls,
    input  logic [ROWS*(COLS+1)-1:0]   v_walls,
    input  logic [FXW-1:0]             food_x,
    input  logic [FYW-1:0]             food_y,
    input  logic                       food_en,
    input  logic [23:0]                wall_color,
    input  logic [23:0]                food_color,
    input  logic [23:0]                bg_color,
    maze_scene_renderer_if.master      tft,
    output logic                       busy,
    output logic                       done
);

    localparam int XW  = (SCENE_WIDTH > 1) ? $clog2(SCENE_WIDTH) : 1;
    localparam int YW  = (SCENE_HEIGHT > 1) ? $clog2(SCENE_HEIGHT) : 1;
    localparam int BW  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam int CSL = $clog2(CELL_SIZE);
    localparam int HW  = (ROWS + 1) * COLS;
    localparam int VW  = ROWS * (COLS + 1);

    typedef logic [CSL-1:0] off_t;

    localparam off_t WT_LO = off_t'(WALL_THICK);
    localparam off_t WT_HI = off_t'(CELL_SIZE - WALL_THICK);
    localparam off_t FD_LO = off_t'(CELL_SIZE / 4);
    localparam off_t FD_HI = off_t'(3 * CELL_SIZE / 4);

    localparam logic [XW-1:0] X_LAST = XW'(SCENE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCENE_HEIGHT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BYTES_PER_PIXEL - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GUARD,
        WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [BW-1:0]     byte_q, byte_d;
    logic [23:0]       pix_q, pix_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic [FXW-1:0]    fx_q, fx_d;
    logic [FYW-1:0]    fy_q, fy_d;
    logic              fen_q, fen_d;
    logic [23:0]       wc_q, wc_d;
    logic [23:0]       fc_q, fc_d;
    logic [23:0]       bc_q, bc_d;

    logic [31:0]       col, row;
    off_t              ox, oy;
    logic [VW-1:0]     vl_s, vr_s;
    logic [HW-1:0]     ht_s, hb_s;
    logic              is_wall, is_food;
    logic [23:0]       pix_c;

    function automatic logic [7:0] pick(input logic [23:0] c,
                                        input logic [BW-1:0] b);
        logic [7:0] r;
        if (b == BW'(0))      r = c[23:16];
        else if (b == BW'(1)) r = c[15:8];
        else                  r = c[7:0];
        return r;
    endfunction

    // Pixel classification for the current (x,y); priority wall > food > bg.
    always_comb begin
        col  = 32'(x_q) >> CSL;
        row  = 32'(y_q) >> CSL;
        ox   = x_q[CSL-1:0];
        oy   = y_q[CSL-1:0];
        vl_s = v_walls >> (row * (COLS + 1) + col);
        vr_s = v_walls >> (row * (COLS + 1) + col + 1);
        ht_s = h_walls >> (row * COLS + col);
        hb_s = h_walls >> ((row + 1) * COLS + col);
        is_wall = (ox < WT_LO && vl_s[0]) ||
                  (ox >= WT_HI && vr_s[0]) ||
                  (oy < WT_LO && ht_s[0]) ||
                  (oy >= WT_HI && hb_s[0]);
        is_food = fen_q &&
                  col == 32'(fx_q) && row == 32'(fy_q) &&
                  ox >= FD_LO && ox < FD_HI &&
                  oy >= FD_LO && oy < FD_HI;
        pix_c = is_wall ? wc_q : (is_food ? fc_q : bc_q);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        byte_d  = byte_q;
        pix_d   = pix_q;
        data_d  = data_q;
        done_d  = 1'b0;
        fx_d    = fx_q;
        fy_d    = fy_q;
        fen_d   = fen_q;
        wc_d    = wc_q;
        fc_d    = fc_q;
        bc_d    = bc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    x_d     = '0;
                    y_d     = '0;
                    byte_d  = '0;
                    fx_d    = food_x;
                    fy_d    = food_y;
                    fen_d   = food_en;
                    wc_d    = wall_color;
                    fc_d    = food_color;
                    bc_d    = bg_color;
                end
            end
            LOAD: begin
                pix_d = pix_c;
                if (!tft.tft_busy) begin
                    state_d = SEND;
                    data_d  = pick(pix_c, '0);
                end
            end
            SEND:  state_d = GUARD;
            GUARD: state_d = WAIT;
            WAIT: begin
                if (!tft.tft_busy) begin
                    if (byte_q != B_LAST) begin
                        byte_d  = byte_q + 1'b1;
                        data_d  = pick(pix_q, byte_q + 1'b1);
                        state_d = SEND;
                    end else begin
                        byte_d = '0;
                        if (x_q != X_LAST) begin
                            x_d     = x_q + 1'b1;
                            state_d = LOAD;
                        end else if (y_q != Y_LAST) begin
                            x_d     = '0;
                            y_d     = y_q + 1'b1;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            byte_q  <= '0;
            pix_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            fx_q    <= '0;
            fy_q    <= '0;
            fen_q   <= 1'b0;
            wc_q    <= '0;
            fc_q    <= '0;
            bc_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            byte_q  <= byte_d;
            pix_q   <= pix_d;
            data_q  <= data_d;
            done_q  <= done_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            fen_q   <= fen_d;
            wc_q    <= wc_d;
            fc_q    <= fc_d;
            bc_q    <= bc_d;
        end
    end

    assign tft.tft_dc       = 1'b1;
    assign tft.tft_data     = data_q;
    assign tft.tft_transmit = (state_q == SEND);
    assign busy             = (state_q != IDLE);
    assign done             = done_q;

endmodule

// File: tb/tb_maze_scene_renderer.sv
// Bench for maze_scene_renderer: three small configurations against a
// pixel-level reference model of the maze drawing rules.
module tb_maze_scene_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [3];
    logic [5:0]  h_walls = '0;
    logic [5:0]  v_walls = '0;
    logic [0:0]  food_x = '0;
    logic [0:0]  food_y = '0;
    logic        food_en = 1'b0;
    logic [23:0] wall_color = '0;
    logic [23:0] food_color = '0;
    logic [23:0] bg_color = '0;
    logic        hold = 1'b0;

    logic        busy_w [3];
    logic        done_w [3];
    logic        tx_w [3];
    logic        dc_w [3];
    logic [7:0]  data_w [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int scnt [3] = '{0, 0, 0};
    int strobes [3] = '{0, 0, 0};
    int done_cnt [3] = '{0, 0, 0};
    int last_tx [3] = '{-100, -100, -100};
    int gap_err [3] = '{0, 0, 0};
    int ovl_err [3] = '{0, 0, 0};
    logic [7:0] log_mem [3][2048];

    maze_scene_renderer_if if_a ();
    maze_scene_renderer_if if_b ();
    maze_scene_renderer_if if_c ();

    maze_scene_renderer #(
        .SCENE_WIDTH(8), .SCENE_HEIGHT(8), .CELL_SIZE(4),
        .WALL_THICK(1), .BYTES_PER_PIXEL(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .h_walls(h_walls), .v_walls(v_walls),
        .food_x(food_x), .food_y(food_y), .food_en(food_en),
        .wall_color(wall_color), .food_color(food_color),
        .bg_color(bg_color), .tft(if_a),
        .busy(busy_w[0]), .done(done_w[0])
    );

    maze_scene_renderer #(
        .SCENE_WIDTH(8), .SCENE_HEIGHT(8), .CELL_SIZE(4),
        .WALL_THICK(1), .BYTES_PER_PIXEL(3)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .h_walls(h_walls), .v_walls(v_walls),
        .food_x(food_x), .food_y(food_y), .food_en(food_en),
        .wall_color(wall_color), .food_color(food_color),
        .bg_color(bg_color), .tft(if_b),
        .busy(busy_w[1]), .done(done_w[1])
    );

    maze_scene_renderer #(
        .SCENE_WIDTH(16), .SCENE_HEIGHT(16), .CELL_SIZE(8),
        .WALL_THICK(3), .BYTES_PER_PIXEL(2)
    ) dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .h_walls(h_walls), .v_walls(v_walls),
        .food_x(food_x), .food_y(food_y), .food_en(food_en),
        .wall_color(wall_color), .food_color(food_color),
        .bg_color(bg_color), .tft(if_c),
        .busy(busy_w[2]), .done(done_w[2])
    );

    assign tx_w[0]   = if_a.tft_transmit;
    assign tx_w[1]   = if_b.tft_transmit;
    assign tx_w[2]   = if_c.tft_transmit;
    assign dc_w[0]   = if_a.tft_dc;
    assign dc_w[1]   = if_b.tft_dc;
    assign dc_w[2]   = if_c.tft_dc;
    assign data_w[0] = if_a.tft_data;
    assign data_w[1] = if_b.tft_data;
    assign data_w[2] = if_c.tft_data;

    assign if_a.tft_busy = hold || (scnt[0] != 0);
    assign if_b.tft_busy = hold || (scnt[1] != 0);
    assign if_c.tft_busy = hold || (scnt[2] != 0);

    always #5 clk = ~clk;

    // Sender model: busy for two cycles following every strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (tx_w[k]) scnt[k] <= 2;
            else if (scnt[k] > 0) scnt[k] <= scnt[k] - 1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (tx_w[k]) begin
                if (cyc - last_tx[k] < 3) gap_err[k]++;
                last_tx[k] = cyc;
                log_mem[k][strobes[k] % 2048] = data_w[k];
                strobes[k]++;
            end
            if (done_w[k]) done_cnt[k]++;
            if (done_w[k] && busy_w[k]) ovl_err[k]++;
        end
    end

    function automatic int p_w(input int k);
        return (k < 2) ? 8 : 16;
    endfunction

    function automatic int p_cell(input int k);
        return (k < 2) ? 4 : 8;
    endfunction

    function automatic int p_thick(input int k);
        return (k < 2) ? 1 : 3;
    endfunction

    function automatic int p_bpp(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic logic wb(input logic [5:0] v, input int i);
        logic [5:0] s;
        s = v >> i;
        return s[0];
    endfunction

    // Reference drawing: the grid is 2x2 cells in every configuration.
    function automatic logic [7:0] exp_byte(input int k, input int x,
                                            input int y, input int b);
        int c, t, col, row, ox, oy;
        logic wall, food;
        logic [23:0] clr, sh;
        c = p_cell(k);
        t = p_thick(k);
        col = x / c;
        ox = x % c;
        row = y / c;
        oy = y % c;
        wall = (ox < t && wb(v_walls, row * 3 + col)) ||
               (ox >= c - t && wb(v_walls, row * 3 + col + 1)) ||
               (oy < t && wb(h_walls, row * 2 + col)) ||
               (oy >= c - t && wb(h_walls, (row + 1) * 2 + col));
        food = food_en && col == int'(food_x) && row == int'(food_y) &&
               ox >= c / 4 && ox < 3 * c / 4 &&
               oy >= c / 4 && oy < 3 * c / 4;
        clr = wall ? wall_color : (food ? food_color : bg_color);
        sh = clr >> (16 - 8 * b);
        return sh[7:0];
    endfunction

    task automatic pulse_start(input int k);
        @(negedge clk);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic finish_frame(input int k, input int s0, input int d0,
                                input string name);
        int t, n, bad, first;
        logic [7:0] got, want;
        t = 0;
        while (done_cnt[k] == d0 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_cnt[k] == d0) begin
            errors++;
            $display("FAIL %s timeout: done not seen in %0d cycles", name, t);
        end
        @(negedge clk);
        n = p_w(k) * p_w(k) * p_bpp(k);
        checks++;
        if (strobes[k] - s0 !== n) begin
            errors++;
            $display("FAIL %s strobes: got %0d want %0d",
                     name, strobes[k] - s0, n);
        end
        bad = 0;
        first = -1;
        got = '0;
        want = '0;
        for (int y = 0; y < p_w(k); y++)
            for (int x = 0; x < p_w(k); x++)
                for (int b = 0; b < p_bpp(k); b++) begin
                    int i;
                    i = ((y * p_w(k) + x) * p_bpp(k) + b);
                    if (log_mem[k][(s0 + i) % 2048] !== exp_byte(k, x, y, b)) begin
                        if (first < 0) begin
                            first = i;
                            got = log_mem[k][(s0 + i) % 2048];
                            want = exp_byte(k, x, y, b);
                        end
                        bad++;
                    end
                end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s bytes: %0d wrong, first at %0d got %02h want %02h",
                     name, bad, first, got, want);
        end
        checks++;
        if (done_cnt[k] - d0 !== 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d want 1",
                     name, done_cnt[k] - d0);
        end
    endtask

    task automatic run_frame(input int k, input string name);
        int s0, d0;
        s0 = strobes[k];
        d0 = done_cnt[k];
        pulse_start(k);
        finish_frame(k, s0, d0, name);
    endtask

    task automatic wait_strobes(input int k, input int target,
                                input string name);
        int t;
        t = 0;
        while (strobes[k] < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (strobes[k] < target) begin
            errors++;
            $display("FAIL %s wait: got %0d strobes want %0d",
                     name, strobes[k], target);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({tx_w[k], busy_w[k], done_w[k]} !== 3'b000) begin
                errors++;
                $display("FAIL reset_ctl dut%0d: got %b want 000",
                         k, {tx_w[k], busy_w[k], done_w[k]});
            end
            checks++;
            if (data_w[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset_data dut%0d: got %02h want 00",
                         k, data_w[k]);
            end
            checks++;
            if (dc_w[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_dc dut%0d: got %b want 1", k, dc_w[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_plain;
        h_walls = '0;
        v_walls = '0;
        food_en = 1'b0;
        bg_color = 24'h123456;
        wall_color = 24'hFE0000;
        food_color = 24'h00FF00;
        run_frame(0, "plain_bpp1");
    endtask

    task automatic test_wall;
        v_walls = 6'b000001;
        run_frame(0, "wall_bpp1");
        v_walls = '0;
    endtask

    task automatic test_food;
        food_x = 1'b1;
        food_y = 1'b1;
        food_en = 1'b1;
        run_frame(1, "food_bpp3");
        // Left wall of cell (1,1) reaches into its food square at x=10.
        v_walls = 6'b010000;
        run_frame(2, "food_wall_prio");
        v_walls = '0;
    endtask

    task automatic test_stall;
        int s0, d0, n0;
        food_en = 1'b0;
        s0 = strobes[0];
        d0 = done_cnt[0];
        pulse_start(0);
        wait_strobes(0, s0 + 20, "stall");
        hold = 1'b1;
        n0 = strobes[0];
        repeat (50) @(negedge clk);
        checks++;
        if (strobes[0] !== n0 || busy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: strobes %0d want %0d busy %b want 1",
                     strobes[0], n0, busy_w[0]);
        end
        hold = 1'b0;
        finish_frame(0, s0, d0, "stall_frame");
    endtask

    task automatic test_start_ignored;
        int s0, d0;
        s0 = strobes[0];
        d0 = done_cnt[0];
        pulse_start(0);
        repeat (30) @(negedge clk);
        pulse_start(0);
        finish_frame(0, s0, d0, "start_ignored");
        repeat (20) @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b0 || strobes[0] - s0 !== 64) begin
            errors++;
            $display("FAIL start_ignored_after: busy %b strobes %0d want 0 64",
                     busy_w[0], strobes[0] - s0);
        end
    endtask

    task automatic test_abort;
        int s0, d0, n0;
        s0 = strobes[0];
        d0 = done_cnt[0];
        pulse_start(0);
        wait_strobes(0, s0 + 20, "abort");
        @(negedge clk);
        rst = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({tx_w[0], busy_w[0], done_w[0]} !== 3'b000 ||
            data_w[0] !== 8'h00) begin
            errors++;
            $display("FAIL abort_outputs: ctl %b data %02h want 000 00",
                     {tx_w[0], busy_w[0], done_w[0]}, data_w[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        start_v[0] = 1'b0;
        n0 = strobes[0];
        repeat (30) @(negedge clk);
        checks++;
        if (done_cnt[0] !== d0 || strobes[0] !== n0 || busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: done %0d want %0d strobes %0d want %0d busy %b",
                     done_cnt[0], d0, strobes[0], n0, busy_w[0]);
        end
        run_frame(0, "after_abort");
    endtask

    task automatic test_random;
        for (int i = 0; i < 3; i++) begin
            h_walls = 6'($urandom);
            v_walls = 6'($urandom);
            food_x = 1'($urandom);
            food_y = 1'($urandom);
            food_en = 1'($urandom_range(0, 1));
            wall_color = 24'($urandom);
            food_color = 24'($urandom);
            bg_color = 24'($urandom);
            run_frame(0, "rand_bpp1");
            run_frame(1, "rand_bpp3");
            run_frame(2, "rand_bpp2");
        end
    endtask

    task automatic test_invariants;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (gap_err[k] !== 0 || ovl_err[k] !== 0) begin
                errors++;
                $display("FAIL invariants dut%0d: gap %0d overlap %0d want 0 0",
                         k, gap_err[k], ovl_err[k]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
        test_reset();
        test_plain();
        test_wall();
        test_food();
        test_stall();
        test_start_ignored();
        test_abort();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
